ama_riscv_mem_arbiter: RTL

Arbitrates a single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (load/store from the MEM stage).
- Data has priority by default; a starvation counter guarantees fetch progress.
- One transaction is outstanding at a time. The memory side uses a req/ack handshake with variable latency.
- Sits between the pipeline stages and the memory model. The pipeline control uses the grant/valid pulses to generate stalls.

---
 rtl/ama_riscv_mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ama_riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ama_riscv_mem_arbiter
// Shares one single-port unified memory between instruction fetch (IF stage)
// and load/store (MEM stage). Data wins by default; a starvation counter
// forces a fetch grant after STARVE_LIMIT data grants with fetch waiting.
// Only one memory transaction is outstanding at a time.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   if_req/if_addr  : fetch request and address, held until if_gnt
//   if_flush        : redirect, drops the response of an in-flight fetch
//   if_gnt/if_valid : fetch accepted / fetched word valid (1-cycle pulses)
//   if_rdata        : registered fetched instruction
//   d_req/d_we/d_addr/d_wdata : data request, byte enables (0 = load), addr, store data
//   d_gnt/d_valid   : data accepted / load data valid or store done (pulses)
//   d_rdata         : registered load data
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request, held until mem_ack
//   mem_ack/mem_rdata : memory completion with same-cycle read data
//   busy            : high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module ama_riscv_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic                if_gnt,
   output logic                if_valid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic [DATA_W/8-1:0] d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_valid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int         BE_W       = DATA_W / 8;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t              state_q;
   logic [3:0]          starveCnt_q, starveCnt_d;
   logic                drop_q;
   logic                memReq_q;
   logic [BE_W-1:0]     memWe_q;
   logic [ADDR_W-1:0]   memAddr_q;
   logic [DATA_W-1:0]   memWdata_q;
   logic                ifValid_q, dValid_q;
   logic [DATA_W-1:0]   ifRdata_q, dRdata_q;
   logic                dWins;

   // Winner selection in IDLE. Data loses only when fetch is waiting and has
   // already been passed over STARVE_LIMIT times. Grants are masked in reset
   // so every output reads 0 while rst is held.
   always_comb begin
      dWins  = d_req && !(if_req && (starveCnt_q == STARVE_MAX));
      d_gnt  = 1'b0;
      if_gnt = 1'b0;
      if (!rst && (state_q == IDLE)) begin
         d_gnt  = dWins;
         if_gnt = if_req && !dWins;
      end
   end

   // Starvation counter: counts data grants that bypassed a waiting fetch,
   // saturates at the limit, and restarts whenever fetch is served or idle.
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (!if_req || if_gnt) begin
         starveCnt_d = 4'd0;
      end else if (d_gnt && (starveCnt_q < STARVE_MAX)) begin
         starveCnt_d = starveCnt_q + 4'd1;
      end
   end

   // Main FSM with registered memory-side and response outputs. The memory
   // request is captured at the grant edge and held until the ack edge; the
   // owner's valid pulse is produced one cycle after the ack. mem_ack is only
   // looked at in the BUSY states, so stray acks in IDLE are harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         starveCnt_q <= 4'd0;
         drop_q      <= 1'b0;
         memReq_q    <= 1'b0;
         memWe_q     <= '0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         ifValid_q   <= 1'b0;
         dValid_q    <= 1'b0;
         ifRdata_q   <= '0;
         dRdata_q    <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
         ifValid_q   <= 1'b0;
         dValid_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               drop_q <= 1'b0;
               if (d_gnt) begin
                  memReq_q   <= 1'b1;
                  memWe_q    <= d_we;
                  memAddr_q  <= d_addr;
                  memWdata_q <= d_wdata;
                  state_q    <= BUSY_D;
               end else if (if_gnt) begin
                  memReq_q   <= 1'b1;
                  memWe_q    <= '0;
                  memAddr_q  <= if_addr;
                  memWdata_q <= '0;
                  state_q    <= BUSY_I;
               end
            end
            BUSY_I: begin
               // A flush in the ack cycle itself must also drop the response,
               // so the live if_flush is combined with the sticky flag.
               if (if_flush) begin
                  drop_q <= 1'b1;
               end
               if (mem_ack) begin
                  memReq_q <= 1'b0;
                  drop_q   <= 1'b0;
                  state_q  <= IDLE;
                  if (!(drop_q || if_flush)) begin
                     ifValid_q <= 1'b1;
                     ifRdata_q <= mem_rdata;
                  end
               end
            end
            BUSY_D: begin
               // Stores still complete with d_valid but keep the last load data.
               if (mem_ack) begin
                  memReq_q <= 1'b0;
                  dValid_q <= 1'b1;
                  state_q  <= IDLE;
                  if (memWe_q == '0) begin
                     dRdata_q <= mem_rdata;
                  end
               end
            end
            default: begin
               memReq_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign mem_req   = memReq_q;
   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign if_valid  = ifValid_q;
   assign if_rdata  = ifRdata_q;
   assign d_valid   = dValid_q;
   assign d_rdata   = dRdata_q;
   assign busy      = (state_q != IDLE);

endmodule
